irq_watchdog_ctrl: RTL and testbench



---
 rtl/centipede_ctrl_pkg.sv | 11 +
 rtl/fall_edge_det.sv | 19 +
 rtl/irq_watchdog_ctrl.sv | 128 ++++++++++++
 tb/tb_irq_watchdog_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/centipede_ctrl_pkg.sv
// Shared types and default sizing for the CPU interrupt/watchdog controller.
package centipede_ctrl_pkg;

  typedef enum logic {RST_PULSE, RUN} wd_state_t;

  localparam int DEF_IRQ_PERIOD   = 64;
  localparam int DEF_IRQ_OFFSET   = 16;
  localparam int DEF_WD_FRAMES    = 16;
  localparam int DEF_RESET_CYCLES = 32;

endpackage

// File: rtl/fall_edge_det.sv
// Turns an active-low decoder strobe into a single-clock pulse on its falling edge.
// The pulse is combinational in the cycle the strobe is first seen low; the history flop resets high.
module fall_edge_det (
  input  logic clk,
  input  logic rst_l,
  input  logic strobe_n,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) prev <= 1'b1;
    else        prev <= strobe_n;
  end

  assign pulse = prev & ~strobe_n;

endmodule

// File: rtl/irq_watchdog_ctrl.sv
// Scanline IRQ generator, frame watchdog and CPU reset sequencer; irq_n asserts 1 clock after the firing line_tick.
// Optional saturating missed-IRQ counter built only when IRQ_MISS_CNT_EN is defined.
module irq_watchdog_ctrl
  import centipede_ctrl_pkg::*;
#(
  parameter int IRQ_PERIOD   = DEF_IRQ_PERIOD,
  parameter int IRQ_OFFSET   = DEF_IRQ_OFFSET,
  parameter int WD_FRAMES    = DEF_WD_FRAMES,
  parameter int RESET_CYCLES = DEF_RESET_CYCLES
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       line_tick,
  input  logic [7:0] vcount,
  input  logic       frame_tick,
  input  logic       irqres_n,
  input  logic       watchdog_n,
  output logic       irq_n,
  output logic       cpu_reset_n,
  output logic [4:0] wd_count,
  output logic [3:0] irq_miss
);

  localparam int VW = $clog2(IRQ_PERIOD);
  localparam int PW = $clog2(RESET_CYCLES);

  wd_state_t     state, state_nxt;
  logic [PW-1:0] pulse_cnt, pulse_cnt_nxt;
  logic [4:0]    wd_cnt, wd_cnt_nxt;
  logic          irq_pend, irq_pend_nxt;
  logic          irq_clr, wd_kick, irq_fire, wd_trip;

  fall_edge_det u_irqres_edge (
    .clk      (clk),
    .rst_l    (rst_l),
    .strobe_n (irqres_n),
    .pulse    (irq_clr)
  );

  fall_edge_det u_wd_edge (
    .clk      (clk),
    .rst_l    (rst_l),
    .strobe_n (watchdog_n),
    .pulse    (wd_kick)
  );

  // Only the low bits of vcount matter since IRQ_PERIOD is a power of two.
  assign irq_fire = line_tick && (vcount[VW-1:0] == VW'(IRQ_OFFSET));
  assign wd_trip  = frame_tick && !wd_kick && (wd_cnt == 5'(WD_FRAMES - 1));

  generate
    if (VW < 8) begin : g_vcount_hi
      logic unused_vcount_hi;
      assign unused_vcount_hi = &{1'b0, vcount[7:VW]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state     <= RST_PULSE;
      pulse_cnt <= '0;
      wd_cnt    <= '0;
      irq_pend  <= 1'b0;
    end else begin
      state     <= state_nxt;
      pulse_cnt <= pulse_cnt_nxt;
      wd_cnt    <= wd_cnt_nxt;
      irq_pend  <= irq_pend_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pulse_cnt_nxt = pulse_cnt;
    wd_cnt_nxt    = wd_cnt;
    irq_pend_nxt  = irq_pend;
    case (state)
      RST_PULSE: begin
        irq_pend_nxt = 1'b0;
        wd_cnt_nxt   = '0;
        if (pulse_cnt == PW'(RESET_CYCLES - 1)) begin
          state_nxt     = RUN;
          pulse_cnt_nxt = '0;
        end else begin
          pulse_cnt_nxt = pulse_cnt + 1'b1;
        end
      end
      RUN: begin
        // Set beats clear so an IRQ landing on the acknowledge cycle is kept.
        if (irq_fire)     irq_pend_nxt = 1'b1;
        else if (irq_clr) irq_pend_nxt = 1'b0;
        if (wd_kick) begin
          wd_cnt_nxt = '0;
        end else if (wd_trip) begin
          state_nxt     = RST_PULSE;
          pulse_cnt_nxt = '0;
          wd_cnt_nxt    = '0;
          irq_pend_nxt  = 1'b0;
        end else if (frame_tick && (wd_cnt != 5'(WD_FRAMES))) begin
          wd_cnt_nxt = wd_cnt + 1'b1;
        end
      end
      default: state_nxt = RST_PULSE;
    endcase
  end

  assign irq_n       = ~irq_pend;
  assign cpu_reset_n = (state == RUN);
  assign wd_count    = wd_cnt;

`ifdef IRQ_MISS_CNT_EN
  logic [3:0] miss_cnt;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)
      miss_cnt <= '0;
    else if ((state == RUN) && wd_trip)
      miss_cnt <= '0;
    else if ((state == RUN) && irq_fire && irq_pend && (miss_cnt != 4'hF))
      miss_cnt <= miss_cnt + 1'b1;
  end

  assign irq_miss = miss_cnt;
`else
  assign irq_miss = 4'd0;
`endif

endmodule

// File: tb/tb_irq_watchdog_ctrl.sv
// Directed self-checking bench for irq_watchdog_ctrl with hand-computed expectations.
module tb_irq_watchdog_ctrl;

  logic       clk = 1'b0;
  logic       rst_l;
  logic       line_tick;
  logic [7:0] vcount;
  logic       frame_tick;
  logic       irqres_n;
  logic       watchdog_n;
  logic       irq_n;
  logic       cpu_reset_n;
  logic [4:0] wd_count;
  logic [3:0] irq_miss;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef IRQ_MISS_CNT_EN
  localparam int MISS_AFTER_COLLISION = 1;
`else
  localparam int MISS_AFTER_COLLISION = 0;
`endif

  always #5 clk = ~clk;

  irq_watchdog_ctrl dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .line_tick   (line_tick),
    .vcount      (vcount),
    .frame_tick  (frame_tick),
    .irqres_n    (irqres_n),
    .watchdog_n  (watchdog_n),
    .irq_n       (irq_n),
    .cpu_reset_n (cpu_reset_n),
    .wd_count    (wd_count),
    .irq_miss    (irq_miss)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic line(input int v);
    vcount    = 8'(v);
    line_tick = 1'b1;
    step();
    line_tick = 1'b0;
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  // Counts cycles cpu_reset_n is low starting from the current (already low) cycle.
  task automatic measure_pulse(output int n, output int stray);
    n     = 1;
    stray = 0;
    while (cpu_reset_n === 1'b0 && n < 200) begin
      if (irq_n !== 1'b1 || wd_count !== 5'd0) stray++;
      step();
      if (cpu_reset_n === 1'b0) n++;
    end
  endtask

  initial begin
    int n, stray, fires, stray_irq, rst_seen;
    rst_l      = 1'b0;
    line_tick  = 1'b0;
    vcount     = 8'd0;
    frame_tick = 1'b0;
    irqres_n   = 1'b1;
    watchdog_n = 1'b1;

    repeat (3) step();
    check("rst_irq_n", irq_n, 1);
    check("rst_cpu_reset_n", cpu_reset_n, 0);
    check("rst_wd_count", wd_count, 0);
    check("rst_irq_miss", irq_miss, 0);

    rst_l = 1'b1;
    measure_pulse(n, stray);
    check("por_pulse_len", n, 32);
    check("por_pulse_stray", stray, 0);
    check("por_released", cpu_reset_n, 1);

    // IRQ cadence across one full frame of 256 lines, 8 clocks each.
    fires     = 0;
    stray_irq = 0;
    for (int v = 0; v < 256; v++) begin
      line(v);
      if (v == 16 || v == 80 || v == 144 || v == 208) begin
        check($sformatf("irq_low_v%0d", v), irq_n, 0);
        if (irq_n === 1'b0) fires++;
        irqres_n = 1'b0;
        step();
        check($sformatf("irq_clear_v%0d", v), irq_n, 1);
        repeat (2) step();
        irqres_n = 1'b1;
        repeat (4) step();
      end else begin
        if (irq_n !== 1'b1) stray_irq++;
        repeat (7) step();
      end
    end
    check("irq_per_frame", fires, 4);
    check("irq_stray_lines", stray_irq, 0);

    // Set/clear collision at vcount 80 with the line-16 IRQ still pending.
    line(16);
    step();
    check("collision_pending", irq_n, 0);
    repeat (6) step();
    vcount    = 8'd80;
    line_tick = 1'b1;
    irqres_n  = 1'b0;
    step();
    line_tick = 1'b0;
    check("collision_set_wins", irq_n, 0);
    check("collision_miss", irq_miss, MISS_AFTER_COLLISION);
    irqres_n = 1'b1;
    step();
    irqres_n = 1'b0;
    step();
    check("clear_after_collision", irq_n, 1);
    irqres_n = 1'b1;
    step();

    // Watchdog trip after 16 frames without a kick; pending IRQ must be dropped.
    repeat (15) frame();
    check("wd_count_15", wd_count, 15);
    check("wd_no_reset_yet", cpu_reset_n, 1);
    line(16);
    step();
    check("trip_irq_pending", irq_n, 0);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("trip_cpu_reset_n", cpu_reset_n, 0);
    check("trip_wd_count", wd_count, 0);
    check("trip_irq_n", irq_n, 1);
    check("trip_irq_miss", irq_miss, 0);
    measure_pulse(n, stray);
    check("trip_pulse_len", n, 32);
    check("trip_pulse_stray", stray, 0);

    // Kick coincident with the 16th frame_tick.
    repeat (15) frame();
    check("kick_pre_count", wd_count, 15);
    frame_tick = 1'b1;
    watchdog_n = 1'b0;
    step();
    frame_tick = 1'b0;
    watchdog_n = 1'b1;
    check("kick_wd_count", wd_count, 0);
    check("kick_no_reset", cpu_reset_n, 1);
    step();

    rst_seen = 0;
    for (int k = 1; k <= 100; k++) begin
      frame_tick = 1'b1;
      if (k % 16 == 0) watchdog_n = 1'b0;
      step();
      frame_tick = 1'b0;
      watchdog_n = 1'b1;
      if (cpu_reset_n !== 1'b1) rst_seen++;
      step();
      if (cpu_reset_n !== 1'b1) rst_seen++;
    end
    check("kick100_no_reset", rst_seen, 0);
    check("kick100_wd_count", wd_count, 4);

    // Async reset at clock 10 of a watchdog reset pulse.
    repeat (11) frame();
    check("pre_trip2_count", wd_count, 15);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("trip2_cpu_reset_n", cpu_reset_n, 0);
    repeat (9) step();
    check("trip2_mid_pulse", cpu_reset_n, 0);
    #2;
    rst_l = 1'b0;
    #1;
    check("async_cpu_reset_n", cpu_reset_n, 0);
    check("async_irq_n", irq_n, 1);
    check("async_wd_count", wd_count, 0);
    check("async_irq_miss", irq_miss, 0);
    repeat (3) step();
    rst_l = 1'b1;
    measure_pulse(n, stray);
    check("async_fresh_pulse_len", n, 32);
    check("async_fresh_pulse_stray", stray, 0);
    check("async_released", cpu_reset_n, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
